// File: rtl/position_to_array_pkg.sv
// Shared widths and FSM state encoding for the bar-graph position converter.
package position_to_array_pkg;

  localparam int POS_W   = 5;
  localparam int ARRAY_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/position_to_array_level_decoder.sv
// Combinational bar decoder: thermometer code for segments 0..pos plus a one-hot peak marker.
module level_decoder
  import position_to_array_pkg::*;
(
  input  logic [POS_W-1:0]   i_pos,
  input  logic [POS_W-1:0]   i_peak,
  output logic [ARRAY_W-1:0] o_array
);

  logic [ARRAY_W-1:0] w_pos_onehot;
  logic [ARRAY_W-1:0] w_thermo;
  logic [ARRAY_W-1:0] w_peak_onehot;

  assign w_pos_onehot  = {{(ARRAY_W-1){1'b0}}, 1'b1} << i_pos;
  // Shifting out the top bit for pos=31 wraps to zero, and zero minus one gives all ones.
  assign w_thermo      = {w_pos_onehot[ARRAY_W-2:0], 1'b0} - {{(ARRAY_W-1){1'b0}}, 1'b1};
  assign w_peak_onehot = {{(ARRAY_W-1){1'b0}}, 1'b1} << i_peak;
  assign o_array       = w_thermo | w_peak_onehot;

endmodule

// File: rtl/position_to_array.sv
// Position to bar-graph converter with peak-hold/decay marker and valid/ready on both sides.
//
//   state | meaning
//   IDLE  | waiting for a position, i_ready=1
//   CALC  | latched position processed, peak updated, array registered
//   OUT   | o_valid=1 until downstream accepts
module position_to_array
  import position_to_array_pkg::*;
#(
  parameter int peak_hold_count = 3
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [POS_W-1:0]   i_position,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [ARRAY_W-1:0] o_array
);

  localparam int HOLD_W = (peak_hold_count < 1) ? 1 : $clog2(peak_hold_count + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(peak_hold_count);

  state_t r_state;
  state_t w_state_next;

  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   r_peak;
  logic [HOLD_W-1:0]  r_hold;
  logic [ARRAY_W-1:0] r_array;

  logic [POS_W-1:0]   w_peak_new;
  logic [POS_W-1:0]   w_peak_dec;
  logic [HOLD_W-1:0]  w_hold_new;
  logic [ARRAY_W-1:0] w_array;
  logic               w_accept;
  logic               w_calc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_valid) w_state_next = CALC;
      CALC:    w_state_next = OUT;
      OUT:     if (o_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    i_ready = 1'b0;
    o_valid = 1'b0;
    w_calc  = 1'b0;
    case (r_state)
      IDLE:    i_ready = 1'b1;
      CALC:    w_calc  = 1'b1;
      OUT:     o_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_accept   = i_valid & i_ready;
  assign w_peak_dec = r_peak - {{(POS_W-1){1'b0}}, 1'b1};

  // Decay never goes below the current bar, so peak=0 cannot underflow.
  always_comb begin
    w_peak_new = r_peak;
    w_hold_new = r_hold;
    if (r_pos >= r_peak) begin
      w_peak_new = r_pos;
      w_hold_new = HOLD_INIT;
    end else if (r_hold != '0) begin
      w_hold_new = r_hold - {{(HOLD_W-1){1'b0}}, 1'b1};
    end else begin
      w_peak_new = (r_pos > w_peak_dec) ? r_pos : w_peak_dec;
    end
  end

  level_decoder u_level_decoder (
    .i_pos   (r_pos),
    .i_peak  (w_peak_new),
    .o_array (w_array)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos   <= '0;
      r_peak  <= '0;
      r_hold  <= '0;
      r_array <= '0;
    end else begin
      if (w_accept) begin
        r_pos <= i_position;
      end
      if (w_calc) begin
        r_peak  <= w_peak_new;
        r_hold  <= w_hold_new;
        r_array <= w_array;
      end
    end
  end

  assign o_array = r_array;

endmodule

// File: tb/tb_position_to_array.sv
// Directed bench for position_to_array: hold=3 instance for the main sequence, hold=0 instance for decay.
module tb_position_to_array;

  logic        clk;
  logic        reset;
  logic        o_ready;
  logic [4:0]  i_position;
  logic        i_valid_a, i_valid_b;
  logic        i_ready_a, i_ready_b;
  logic        o_valid_a, o_valid_b;
  logic [31:0] o_array_a, o_array_b;

  int n_checks = 0;
  int n_fail   = 0;

  position_to_array #(.peak_hold_count(3)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid_a),
    .i_ready    (i_ready_a),
    .i_position (i_position),
    .o_valid    (o_valid_a),
    .o_ready    (o_ready),
    .o_array    (o_array_a)
  );

  position_to_array #(.peak_hold_count(0)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid_b),
    .i_ready    (i_ready_b),
    .i_position (i_position),
    .o_valid    (o_valid_b),
    .o_ready    (o_ready),
    .o_array    (o_array_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one position to DUT a (sel=0) or b (sel=1) and check the result one cycle after acceptance.
  task automatic send(input logic sel, input logic [4:0] pos, input logic [31:0] exp, input string tag);
    check({tag, "_rdy"}, {31'd0, sel ? i_ready_b : i_ready_a}, 32'd1);
    i_position = pos;
    if (sel) i_valid_b = 1'b1;
    else     i_valid_a = 1'b1;
    tick();
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
    check({tag, "_busy"}, {31'd0, sel ? i_ready_b : i_ready_a}, 32'd0);
    tick();
    check({tag, "_vld"}, {31'd0, sel ? o_valid_b : o_valid_a}, 32'd1);
    check(tag, sel ? o_array_b : o_array_a, exp);
    if (o_ready) tick();
  endtask

  initial begin
    reset      = 1'b0;
    o_ready    = 1'b1;
    i_valid_a  = 1'b0;
    i_valid_b  = 1'b0;
    i_position = 5'd0;
    #12;
    check("rst_i_ready", {31'd0, i_ready_a}, 32'd1);
    check("rst_o_valid", {31'd0, o_valid_a}, 32'd0);
    check("rst_o_array", o_array_a, 32'h0000_0000);
    reset = 1'b1;
    tick();

    send(1'b0, 5'd31, 32'hFFFF_FFFF, "p31");
    send(1'b0, 5'd10, 32'h8000_07FF, "p10_hold");
    send(1'b0, 5'd13, 32'h8000_3FFF, "p13_hold");
    send(1'b0, 5'd9,  32'h8000_03FF, "p9_hold");
    send(1'b0, 5'd3,  32'h4000_000F, "p3_decay30");
    send(1'b0, 5'd2,  32'h2000_0007, "p2_decay29");
    send(1'b0, 5'd1,  32'h1000_0003, "p1_decay28");

    // Backpressure: result and handshake must freeze while downstream stalls.
    o_ready = 1'b0;
    send(1'b0, 5'd7, 32'h0800_00FF, "bp_p7");
    i_position = 5'd3;
    i_valid_a  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_o_valid", {31'd0, o_valid_a}, 32'd1);
      check("bp_o_array", o_array_a, 32'h0800_00FF);
      check("bp_i_ready", {31'd0, i_ready_a}, 32'd0);
    end
    i_valid_a = 1'b0;
    o_ready   = 1'b1;
    tick();
    check("bp_release_i_ready", {31'd0, i_ready_a}, 32'd1);
    check("bp_release_o_valid", {31'd0, o_valid_a}, 32'd0);
    check("bp_array_held", o_array_a, 32'h0800_00FF);

    send(1'b0, 5'd31, 32'hFFFF_FFFF, "np_31");
    send(1'b0, 5'd10, 32'h8000_07FF, "np_10");
    send(1'b0, 5'd31, 32'hFFFF_FFFF, "np_31_again");
    send(1'b0, 5'd5,  32'h8000_003F, "np_hold1");
    send(1'b0, 5'd5,  32'h8000_003F, "np_hold2");
    send(1'b0, 5'd5,  32'h8000_003F, "np_hold3");
    send(1'b0, 5'd5,  32'h4000_003F, "np_decay");

    // Abort a transaction while in CALC.
    i_position = 5'd9;
    i_valid_a  = 1'b1;
    tick();
    i_valid_a = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort_i_ready", {31'd0, i_ready_a}, 32'd1);
    check("abort_o_valid", {31'd0, o_valid_a}, 32'd0);
    check("abort_o_array", o_array_a, 32'h0000_0000);
    #2 reset = 1'b1;
    tick();
    tick();
    check("abort_no_output", {31'd0, o_valid_a}, 32'd0);
    send(1'b0, 5'd0, 32'h0000_0001, "after_rst_p0");

    send(1'b1, 5'd20, 32'h001F_FFFF, "h0_p20");
    send(1'b1, 5'd5,  32'h0008_003F, "h0_decay19");
    send(1'b1, 5'd0,  32'h0004_0001, "h0_decay18");
    send(1'b1, 5'd17, 32'h0003_FFFF, "h0_floor17");
    send(1'b1, 5'd0,  32'h0001_0001, "h0_decay16");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
